// File: rtl/assoc_search.sv
// -----------------------------------------------------------------------------
// assoc_search
// Associative-memory search for the hypervector classifier. A query
// hypervector is captured on start, scored against CLASS_COUNT stored class
// hypervectors by sparse overlap (popcount of AND), DIMS_PER_CC dimensions per
// cycle, and then a sequential argmax picks the best class.
//
// Optional build macro: ASSOC_MARGIN_EN adds second_score and margin outputs
// (second-highest score and best minus second). Timing is identical either way.
//
// Ports:
//   clk              clock, rising edge
//   nrst             asynchronous active-low reset
//   en               global enable; when low every register holds
//   start_search     search request, honoured only in IDLE
//   encoded_hv       query hypervector, captured on the accepted start edge
//   class_hvs        class hypervectors, stable from start until done
//   search_done      one-cycle pulse when the result is valid
//   busy             high whenever the search engine is not idle
//   predicted_class  index of the best-scoring class
//   best_score       overlap score of that class
//   second_score     (ASSOC_MARGIN_EN) second-highest overlap score
//   margin           (ASSOC_MARGIN_EN) best_score - second_score
// -----------------------------------------------------------------------------
module assoc_search #(
   parameter int HV_DIM      = 2048,
   parameter int CLASS_COUNT = 26,
   parameter int DIMS_PER_CC = 256,
   parameter int CHUNKS      = HV_DIM / DIMS_PER_CC,
   parameter int SCORE_W     = $clog2(HV_DIM + 1),
   parameter int CLS_W       = $clog2(CLASS_COUNT)
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 en,
   input  logic                 start_search,
   input  logic [HV_DIM-1:0]    encoded_hv,
   input  logic [HV_DIM-1:0]    class_hvs [0:CLASS_COUNT-1],
   output logic                 search_done,
   output logic                 busy,
   output logic [CLS_W-1:0]     predicted_class,
   output logic [SCORE_W-1:0]   best_score
`ifdef ASSOC_MARGIN_EN
   ,
   output logic [SCORE_W-1:0]   second_score,
   output logic [SCORE_W-1:0]   margin
`endif
);

   localparam int PC_W   = $clog2(DIMS_PER_CC + 1);
   localparam int CTR_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int BASE_W = $clog2(HV_DIM);
   localparam logic [CTR_W-1:0] LAST_CHUNK = CTR_W'(CHUNKS - 1);
   localparam logic [CLS_W-1:0] LAST_CLASS = CLS_W'(CLASS_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCORE  = 2'd1,
      ARGMAX = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t               state_r;
   state_t               next_state_s;
   logic [HV_DIM-1:0]    query_r;
   logic [CTR_W-1:0]     ctr_r;
   logic [CLS_W-1:0]     idx_r;
   logic [SCORE_W-1:0]   acc_r [CLASS_COUNT];
   logic [SCORE_W-1:0]   best_r;
   logic [CLS_W-1:0]     best_idx_r;
   logic [BASE_W-1:0]    chunk_base_s;
   logic [DIMS_PER_CC-1:0] q_chunk_s;
   logic [PC_W-1:0]      pc_s [CLASS_COUNT];
   logic [SCORE_W-1:0]   acc_cur_s;
   logic [SCORE_W-1:0]   best_next_s;
   logic [CLS_W-1:0]     best_idx_next_s;
`ifdef ASSOC_MARGIN_EN
   logic [SCORE_W-1:0]   second_r;
   logic [SCORE_W-1:0]   second_next_s;
`endif

   // Number of set bits in one chunk-wide vector.
   function automatic logic [PC_W-1:0] popcount(input logic [DIMS_PER_CC-1:0] v);
      logic [PC_W-1:0] n;
      n = {PC_W{1'b0}};
      for (int i = 0; i < DIMS_PER_CC; i++) begin
         n = n + {{(PC_W-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

   assign chunk_base_s = BASE_W'(ctr_r) * BASE_W'(DIMS_PER_CC);

   // Per-class overlap of the current query chunk.
   always_comb begin
      q_chunk_s = query_r[chunk_base_s +: DIMS_PER_CC];
      for (int c = 0; c < CLASS_COUNT; c++) begin
         pc_s[c] = popcount(q_chunk_s & class_hvs[c][chunk_base_s +: DIMS_PER_CC]);
      end
   end

   // Argmax step: strict greater-than keeps the lowest index on ties; a score
   // equal to the best still lands in second place.
   always_comb begin
      acc_cur_s       = acc_r[idx_r];
      best_next_s     = best_r;
      best_idx_next_s = best_idx_r;
`ifdef ASSOC_MARGIN_EN
      second_next_s   = second_r;
`endif
      if (acc_cur_s > best_r) begin
         best_next_s     = acc_cur_s;
         best_idx_next_s = idx_r;
`ifdef ASSOC_MARGIN_EN
         second_next_s   = best_r;
`endif
      end else begin
         best_next_s = best_r;
`ifdef ASSOC_MARGIN_EN
         if (acc_cur_s > second_r) begin
            second_next_s = acc_cur_s;
         end else begin
            second_next_s = second_r;
         end
`endif
      end
   end

   // Next-state logic of the search sequencer.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_search) next_state_s = SCORE;
            else              next_state_s = IDLE;
         end
         SCORE: begin
            if (ctr_r == LAST_CHUNK) next_state_s = ARGMAX;
            else                     next_state_s = SCORE;
         end
         ARGMAX: begin
            if (idx_r == LAST_CLASS) next_state_s = DONE;
            else                     next_state_s = ARGMAX;
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Per-class score accumulators: cleared on accept, summed during SCORE.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int c = 0; c < CLASS_COUNT; c++) acc_r[c] <= {SCORE_W{1'b0}};
      end else if (en) begin
         if (state_r == IDLE && start_search) begin
            for (int c = 0; c < CLASS_COUNT; c++) acc_r[c] <= {SCORE_W{1'b0}};
         end else if (state_r == SCORE) begin
            for (int c = 0; c < CLASS_COUNT; c++) begin
               acc_r[c] <= acc_r[c] + {{(SCORE_W-PC_W){1'b0}}, pc_s[c]};
            end
         end
      end
   end

   // Sequencer state, counters, argmax registers and registered outputs.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_r         <= IDLE;
         query_r         <= {HV_DIM{1'b0}};
         ctr_r           <= {CTR_W{1'b0}};
         idx_r           <= {CLS_W{1'b0}};
         best_r          <= {SCORE_W{1'b0}};
         best_idx_r      <= {CLS_W{1'b0}};
         search_done     <= 1'b0;
         busy            <= 1'b0;
         predicted_class <= {CLS_W{1'b0}};
         best_score      <= {SCORE_W{1'b0}};
`ifdef ASSOC_MARGIN_EN
         second_r        <= {SCORE_W{1'b0}};
         second_score    <= {SCORE_W{1'b0}};
         margin          <= {SCORE_W{1'b0}};
`endif
      end else if (en) begin
         state_r     <= next_state_s;
         busy        <= (next_state_s != IDLE);
         search_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_search) begin
                  query_r <= encoded_hv;
                  ctr_r   <= {CTR_W{1'b0}};
               end
            end
            SCORE: begin
               ctr_r <= ctr_r + {{(CTR_W-1){1'b0}}, 1'b1};
               if (ctr_r == LAST_CHUNK) begin
                  idx_r      <= {CLS_W{1'b0}};
                  best_r     <= {SCORE_W{1'b0}};
                  best_idx_r <= {CLS_W{1'b0}};
`ifdef ASSOC_MARGIN_EN
                  second_r   <= {SCORE_W{1'b0}};
`endif
               end
            end
            ARGMAX: begin
               best_r     <= best_next_s;
               best_idx_r <= best_idx_next_s;
`ifdef ASSOC_MARGIN_EN
               second_r   <= second_next_s;
`endif
               if (idx_r == LAST_CLASS) begin
                  // Result is taken from the combinational step so the last
                  // class is included on the edge entering DONE.
                  idx_r           <= {CLS_W{1'b0}};
                  search_done     <= 1'b1;
                  predicted_class <= best_idx_next_s;
                  best_score      <= best_next_s;
`ifdef ASSOC_MARGIN_EN
                  second_score    <= second_next_s;
                  margin          <= best_next_s - second_next_s;
`endif
               end else begin
                  idx_r <= idx_r + {{(CLS_W-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
               search_done <= 1'b0;
            end
            default: begin
               search_done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_assoc_search.sv
// -----------------------------------------------------------------------------
// tb_assoc_search
// Scoreboard bench for assoc_search: each issued search pushes its expected
// class, scores and latencies; a monitor pops and compares on search_done.
// -----------------------------------------------------------------------------
module tb_assoc_search;

   localparam int HV_DIM = 2048;
   localparam int NCLS   = 26;

   logic              clk;
   logic              nrst;
   logic              en;
   logic              start_search;
   logic [HV_DIM-1:0] encoded_hv;
   logic [HV_DIM-1:0] class_hvs [0:NCLS-1];
   logic              search_done;
   logic              busy;
   logic [4:0]        predicted_class;
   logic [11:0]       best_score;
`ifdef ASSOC_MARGIN_EN
   logic [11:0]       second_score;
   logic [11:0]       margin;
`endif

   assoc_search dut (
      .clk             (clk),
      .nrst            (nrst),
      .en              (en),
      .start_search    (start_search),
      .encoded_hv      (encoded_hv),
      .class_hvs       (class_hvs),
      .search_done     (search_done),
      .busy            (busy),
      .predicted_class (predicted_class),
      .best_score      (best_score)
`ifdef ASSOC_MARGIN_EN
      ,
      .second_score    (second_score),
      .margin          (margin)
`endif
   );

   typedef struct {
      int cls;
      int score;
      int second;
      int start_cyc;
      int start_en;
      int cyc_lat;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   en_edges = 0;
   logic [HV_DIM-1:0] hv_a;
   logic [HV_DIM-1:0] hv_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (en) en_edges <= en_edges + 1;
   end

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Bits at offset + 32*i for i < n: spread evenly over all chunks.
   function automatic logic [HV_DIM-1:0] stride(input int offset, input int n);
      logic [HV_DIM-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i*32 + offset] = 1'b1;
      return v;
   endfunction

   // Monitor: compare each done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (nrst && search_done) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got search_done=1 expected none (t=%0t)", $time);
         end else begin
            e = sb_q.pop_front();
            check("predicted_class", int'(predicted_class), e.cls);
            check("best_score", int'(best_score), e.score);
            check("latency_en_edges", en_edges - e.start_en, 34);
            check("latency_cycles", cyc - e.start_cyc, e.cyc_lat);
            check("busy_in_done", int'(busy), 1);
`ifdef ASSOC_MARGIN_EN
            check("second_score", int'(second_score), e.second);
            check("margin", int'(margin), e.score - e.second);
`endif
         end
      end
   end

   // Called at a negedge with the DUT idle; returns after the accepting edge.
   task automatic do_search(input logic [HV_DIM-1:0] hv, input int cls, input int score,
                            input int second, input int cyc_lat);
      exp_t e;
      encoded_hv   = hv;
      start_search = 1'b1;
      e.cls = cls; e.score = score; e.second = second;
      e.start_cyc = cyc + 1; e.start_en = en_edges + 1; e.cyc_lat = cyc_lat;
      sb_q.push_back(e);
      @(posedge clk);
      #1 start_search = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no search_done within %0d cycles, expected one", limit);
         sb_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_done"}, int'(search_done), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_class"}, int'(predicted_class), 0);
      check({tag, "_score"}, int'(best_score), 0);
`ifdef ASSOC_MARGIN_EN
      check({tag, "_second"}, int'(second_score), 0);
      check({tag, "_margin"}, int'(margin), 0);
`endif
   endtask

   task automatic load_tie_classes();
      for (int c = 0; c < NCLS; c++) class_hvs[c] = stride(0, c);
      class_hvs[3]  = stride(0, 40);
      class_hvs[12] = stride(0, 40);
   endtask

   initial begin
      int n;
      en = 1'b1; start_search = 1'b0; encoded_hv = '0;
      for (int c = 0; c < NCLS; c++) class_hvs[c] = '0;
      hv_a = stride(0, 64);
      hv_b = stride(5, 64);
      nrst = 1'b1;
      #2 nrst = 1'b0;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (5) @(negedge clk);
      check_cleared("reset_idle");

      // Exact match on class 7, every other class disjoint from the query.
      for (int c = 0; c < NCLS; c++) class_hvs[c] = ~hv_a;
      class_hvs[7] = hv_a;
      do_search(hv_a, 7, 64, 0, 34);
      wait_done(200);

      // Tie at 40 between classes 3 and 12, others score their own index.
      load_tie_classes();
      do_search(hv_a, 3, 40, 40, 34);
      wait_done(200);

      // Same search with two 10-cycle enable stalls (SCORE and ARGMAX).
      do_search(hv_a, 3, 40, 40, 54);
      repeat (4) @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
      en = 1'b1;
      repeat (12) @(negedge clk);
      en = 1'b0;
      repeat (10) @(negedge clk);
      en = 1'b1;
      wait_done(200);

      // All-zero query: every score 0, class 0 wins.
      do_search('0, 0, 0, 0, 34);
      wait_done(200);

      // Ignored start during ARGMAX, then back-to-back start in first IDLE.
      for (int c = 0; c < NCLS; c++) class_hvs[c] = '0;
      class_hvs[7]  = hv_a;
      class_hvs[25] = hv_b;
      do_search(hv_a, 7, 64, 0, 34);
      repeat (20) @(negedge clk);
      encoded_hv   = hv_b;
      start_search = 1'b1;
      @(negedge clk);
      start_search = 1'b0;
      n = 0;
      while (search_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      do_search(hv_b, 25, 64, 0, 34);
      wait_done(200);

      // Reset in the middle of SCORE: abort with no done, then a fresh search.
      load_tie_classes();
      do_search(hv_a, 3, 40, 40, 34);
      repeat (4) @(negedge clk);
      nrst = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge clk);
      check_cleared("reset_mid");
      nrst = 1'b1;
      repeat (40) @(negedge clk);
      check("reset_mid_idle_busy", int'(busy), 0);
      do_search(hv_a, 3, 40, 40, 34);
      wait_done(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
